// File: rtl/byte_accumulator_pkg.sv
// byte_accumulator_pkg: shared state encoding and widths for the byte accumulator.
package byte_accumulator_pkg;
    typedef enum logic {ACCUM, DONE} state_t;
    localparam int OP_W = 8;
    localparam int RES_W = 16;
    localparam int COUNT_MIN = 1;
    localparam int COUNT_MAX = 255;
endpackage

// File: rtl/full_adder_b.sv
// full_adder_b: 8-bit ripple-carry adder built from single-bit full adders.
module full_adder_b (
    input  logic [7:0] Ain,
    input  logic [7:0] Bin,
    input  logic       Cin,
    output logic [7:0] Sout,
    output logic       Cout
);
    logic [8:0] c;
    assign c[0] = Cin;
    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign Sout[i] = Ain[i] ^ Bin[i] ^ c[i];
        assign c[i+1] = (Ain[i] & Bin[i]) | (c[i] & (Ain[i] ^ Bin[i]));
    end
    assign Cout = c[8];
endmodule

// File: rtl/byte_accumulator.sv
// byte_accumulator: sums frames of COUNT unsigned bytes into a {carry_cnt, acc} total
// presented on a valid/ready output; no new operand is taken while a total is pending.
module byte_accumulator
    import byte_accumulator_pkg::*;
#(
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [OP_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [RES_W-1:0] out_sum,
    output logic             out_valid,
    input  logic             out_ready
);
    if (COUNT < COUNT_MIN || COUNT > COUNT_MAX) begin : g_bad_count
        $error("byte_accumulator: COUNT must be within 1..255");
    end

    state_t state, state_nx;
    logic [OP_W-1:0] acc, carry_cnt, op_cnt, sum;
    logic cout, accept, consume, last;

    full_adder_b u_adder (
        .Ain (acc),
        .Bin (in_data),
        .Cin (1'b0),
        .Sout(sum),
        .Cout(cout)
    );

    always_comb begin
        in_ready = state == ACCUM;
        out_valid = state == DONE;
        accept = in_valid && in_ready;
        consume = out_valid && out_ready;
        last = op_cnt == OP_W'(COUNT - 1);
        state_nx = clr ? ACCUM : (accept && last) ? DONE : consume ? ACCUM : state;
    end

    // Gated so the output reads zero outside DONE instead of exposing partial sums.
    assign out_sum = out_valid ? {carry_cnt, acc} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            carry_cnt <= '0;
            op_cnt <= '0;
        end else if (clr || consume) begin
            acc <= '0;
            carry_cnt <= '0;
            op_cnt <= '0;
        end else if (accept) begin
            acc <= sum;
            carry_cnt <= carry_cnt + {{(OP_W-1){1'b0}}, cout};
            op_cnt <= op_cnt + 1'b1;
        end
    end
endmodule
